// File: rtl/instr_fetch_if.sv
// Bus bundle for the fetch stage: instruction-memory request/response, redirect,
// and the fetch-to-decode handoff.
interface instr_fetch_if #(
   parameter int unsigned XLEN = 64
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            if_valid;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   logic            id_ready;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
      input  id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
      output id_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage with a one-entry skid buffer.
// Optional IF_MISALIGN_CHECK_EN adds fetch_misalign and blocks fetch on misaligned redirects.
module instr_fetch #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           reset,
`ifdef IF_MISALIGN_CHECK_EN
   output logic           fetch_misalign,
`endif
   instr_fetch_if.master  io_fetch
);

   localparam logic [31:0]     NopInstr  = 32'h0000_0013;
   localparam logic [XLEN-1:0] PcStep    = XLEN'(4);
   localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

   typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

   state_e          r_state, w_state_next;
   logic [XLEN-1:0] r_pc, w_pc_next;
   logic [XLEN-1:0] r_wait_pc, w_wait_pc_next;
   logic            r_if_valid, w_if_valid_next;
   logic [31:0]     r_if_instr, w_if_instr_next;
   logic [XLEN-1:0] r_if_pc, w_if_pc_next;
   logic            r_skid_valid, w_skid_valid_next;
   logic [31:0]     r_skid_instr, w_skid_instr_next;
   logic [XLEN-1:0] r_skid_pc, w_skid_pc_next;

   logic            w_inhibit;
   logic [XLEN-1:0] w_redirect_pc;
   logic [XLEN-1:0] w_req_addr;
   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_consume;
   logic            w_resp_take;

`ifdef IF_MISALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (io_fetch.redirect_valid) begin
         r_misalign <= |io_fetch.redirect_pc[1:0];
      end
   end

   assign fetch_misalign = r_misalign;
   assign w_inhibit      = r_misalign;
   assign w_redirect_pc  = io_fetch.redirect_pc;
`else
   assign w_inhibit      = 1'b0;
   assign w_redirect_pc  = io_fetch.redirect_pc & AlignMask;
`endif

   assign w_req_addr  = r_pc & AlignMask;
   assign w_req_valid = !reset && (r_state == StReq) && !io_fetch.redirect_valid &&
                        !r_skid_valid && !w_inhibit;
   assign w_req_fire  = w_req_valid && io_fetch.imem_req_ready;
   assign w_consume   = r_if_valid && io_fetch.id_ready;
   assign w_resp_take = (r_state == StWait) && io_fetch.imem_resp_valid;

   assign io_fetch.imem_req_valid = w_req_valid;
   assign io_fetch.imem_req_addr  = w_req_addr;
   assign io_fetch.if_valid       = r_if_valid;
   assign io_fetch.if_instr       = r_if_instr;
   assign io_fetch.if_pc          = r_if_pc;

   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_wait_pc_next    = r_wait_pc;
      w_if_valid_next   = r_if_valid;
      w_if_instr_next   = r_if_instr;
      w_if_pc_next      = r_if_pc;
      w_skid_valid_next = r_skid_valid;
      w_skid_instr_next = r_skid_instr;
      w_skid_pc_next    = r_skid_pc;

      if (io_fetch.redirect_valid) begin
         w_pc_next         = w_redirect_pc;
         w_if_valid_next   = 1'b0;
         w_skid_valid_next = 1'b0;
         // A response landing with the redirect is the stale one; drop it right here.
         unique case (r_state)
            StReq:   w_state_next = StReq;
            StWait:  w_state_next = io_fetch.imem_resp_valid ? StReq : StDrop;
            StDrop:  w_state_next = io_fetch.imem_resp_valid ? StReq : StDrop;
            default: w_state_next = StReq;
         endcase
      end else begin
         unique case (r_state)
            StReq: begin
               if (w_req_fire) begin
                  w_pc_next      = r_pc + PcStep;
                  w_wait_pc_next = w_req_addr;
                  w_state_next   = StWait;
               end
            end
            StWait:  if (io_fetch.imem_resp_valid) w_state_next = StReq;
            StDrop:  if (io_fetch.imem_resp_valid) w_state_next = StReq;
            default: w_state_next = StReq;
         endcase

         if (w_consume) begin
            if (r_skid_valid) begin
               w_if_instr_next   = r_skid_instr;
               w_if_pc_next      = r_skid_pc;
               w_skid_valid_next = 1'b0;
            end else if (w_resp_take) begin
               w_if_instr_next = io_fetch.imem_resp_data;
               w_if_pc_next    = r_wait_pc;
            end else begin
               w_if_valid_next = 1'b0;
            end
         end else if (w_resp_take) begin
            if (!r_if_valid) begin
               w_if_valid_next = 1'b1;
               w_if_instr_next = io_fetch.imem_resp_data;
               w_if_pc_next    = r_wait_pc;
            end else begin
               // Slot is held by decode; park the word until it drains.
               w_skid_valid_next = 1'b1;
               w_skid_instr_next = io_fetch.imem_resp_data;
               w_skid_pc_next    = r_wait_pc;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StReq;
         r_pc         <= RESET_PC;
         r_wait_pc    <= '0;
         r_if_valid   <= 1'b0;
         r_if_instr   <= NopInstr;
         r_if_pc      <= '0;
         r_skid_valid <= 1'b0;
         r_skid_instr <= NopInstr;
         r_skid_pc    <= '0;
      end else begin
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_wait_pc    <= w_wait_pc_next;
         r_if_valid   <= w_if_valid_next;
         r_if_instr   <= w_if_instr_next;
         r_if_pc      <= w_if_pc_next;
         r_skid_valid <= w_skid_valid_next;
         r_skid_instr <= w_skid_instr_next;
         r_skid_pc    <= w_skid_pc_next;
      end
   end

endmodule
